// File: rtl/mii_rx_mac.sv
`default_nettype none
// ============================================================================
// mii_rx_mac : MII nibble receiver - SFD strip, byte assembly, FCS check/strip
// Revision   : 1.0
// ============================================================================
module mii_rx_mac #(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC  = 1'b0,
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518
) (
  input  logic        i_rx_clk,
  input  logic        i_rstn,
  input  logic        i_mii_rx_dv,
  input  logic        i_mii_rx_er,
  input  logic [3:0]  i_mii_rx_data,
  output logic        o_rx_valid,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_sof,
  output logic        o_rx_eof,
  output logic        o_rx_done,
  output logic [4:0]  o_rx_status,
  output logic [10:0] o_rx_len
);

  localparam logic [10:0] C_MIN_LEN = 11'(MIN_LEN);
  localparam logic [10:0] C_MAX_LEN = 11'(MAX_LEN);
  localparam logic [10:0] C_CNT_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        in_vld_q, in_vld_d;
  logic        first_q, first_d;
  logic        dv_q, dv_d;
  logic        er_q, er_d;
  logic [3:0]  nib_q, nib_d;
  logic        phase_q, phase_d;
  logic [3:0]  lo_q, lo_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] cnt_q, cnt_d;
  logic        mii_err_q, mii_err_d;
  logic        da_hit_q, da_hit_d;
  logic        bc_hit_q, bc_hit_d;
  logic        sof_pend_q, sof_pend_d;
  logic        done_pend_q, done_pend_d;
  logic [39:0] dl_q, dl_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        done_q, done_d;
  logic [4:0]  status_q, status_d;
  logic [10:0] len_q, len_d;

  logic [7:0]  rx_byte;
  logic        crc_err, len_err, addr_hit;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return MAC_ADDR[47:40];
      3'd1:    return MAC_ADDR[39:32];
      3'd2:    return MAC_ADDR[31:24];
      3'd3:    return MAC_ADDR[23:16];
      3'd4:    return MAC_ADDR[15:8];
      3'd5:    return MAC_ADDR[7:0];
      default: return 8'h00;
    endcase
  endfunction

  assign rx_byte  = {nib_q, lo_q};
  assign crc_err  = (crc_q != 32'hDEBB20E3);
  assign len_err  = (cnt_q < C_MIN_LEN) || (cnt_q > C_MAX_LEN);
  assign addr_hit = PROMISC || ((cnt_q >= 11'd6) && (da_hit_q || bc_hit_q));

  always_comb begin
    state_d     = state_q;
    in_vld_d    = 1'b1;
    first_d     = first_q;
    dv_d        = i_mii_rx_dv;
    er_d        = i_mii_rx_er;
    nib_d       = i_mii_rx_data;
    phase_d     = phase_q;
    lo_d        = lo_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    mii_err_d   = mii_err_q;
    da_hit_d    = da_hit_q;
    bc_hit_d    = bc_hit_q;
    sof_pend_d  = sof_pend_q;
    done_pend_d = 1'b0;
    dl_d        = dl_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    done_d      = done_pend_q;
    status_d    = status_q;
    len_d       = len_q;

    // Frame registers are frozen once DATA is left, so status is taken a cycle later.
    if (done_pend_q) begin
      status_d = {addr_hit, mii_err_q, phase_q, len_err, crc_err};
      len_d    = (cnt_q < 11'd4) ? 11'd0 : (cnt_q - 11'd4);
    end

    case (state_q)
      S_IDLE: begin
        // The first real input sample after reset must not start a frame mid-stream.
        if (in_vld_q) begin
          first_d = 1'b0;
          if (dv_q) begin
            state_d = (first_q || (nib_q != 4'h5)) ? S_DROP : S_PRE;
          end
        end
      end
      S_PRE: begin
        if (!dv_q) begin
          state_d = S_IDLE;
        end else if (nib_q == 4'hD) begin
          state_d    = S_DATA;
          cnt_d      = 11'd0;
          phase_d    = 1'b0;
          crc_d      = 32'hFFFF_FFFF;
          mii_err_d  = 1'b0;
          da_hit_d   = 1'b1;
          bc_hit_d   = 1'b1;
          sof_pend_d = 1'b1;
        end else if (nib_q != 4'h5) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (er_q) mii_err_d = 1'b1;
        if (dv_q) begin
          if (!phase_q) begin
            lo_d    = nib_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc_next(crc_q, rx_byte);
            if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + 11'd1;
            if (cnt_q < 11'd6) begin
              if (rx_byte != mac_byte(cnt_q[2:0])) da_hit_d = 1'b0;
              if (rx_byte != 8'hFF) bc_hit_d = 1'b0;
            end
            dl_d = {dl_q[31:0], rx_byte};
            // Five bytes in flight keep the four FCS bytes off the output.
            if (cnt_q >= 11'd5) begin
              valid_d    = 1'b1;
              data_d     = dl_q[39:32];
              sof_d      = sof_pend_q;
              sof_pend_d = 1'b0;
            end
          end
        end else begin
          if (cnt_q >= 11'd5) begin
            valid_d    = 1'b1;
            eof_d      = 1'b1;
            data_d     = dl_q[39:32];
            sof_d      = sof_pend_q;
            sof_pend_d = 1'b0;
          end
          done_pend_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DROP: begin
        if (!dv_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_rx_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      in_vld_q    <= 1'b0;
      first_q     <= 1'b1;
      dv_q        <= 1'b0;
      er_q        <= 1'b0;
      nib_q       <= 4'h0;
      phase_q     <= 1'b0;
      lo_q        <= 4'h0;
      crc_q       <= 32'hFFFF_FFFF;
      cnt_q       <= 11'd0;
      mii_err_q   <= 1'b0;
      da_hit_q    <= 1'b0;
      bc_hit_q    <= 1'b0;
      sof_pend_q  <= 1'b0;
      done_pend_q <= 1'b0;
      dl_q        <= 40'd0;
      valid_q     <= 1'b0;
      data_q      <= 8'h00;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 5'd0;
      len_q       <= 11'd0;
    end else begin
      state_q     <= state_d;
      in_vld_q    <= in_vld_d;
      first_q     <= first_d;
      dv_q        <= dv_d;
      er_q        <= er_d;
      nib_q       <= nib_d;
      phase_q     <= phase_d;
      lo_q        <= lo_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      mii_err_q   <= mii_err_d;
      da_hit_q    <= da_hit_d;
      bc_hit_q    <= bc_hit_d;
      sof_pend_q  <= sof_pend_d;
      done_pend_q <= done_pend_d;
      dl_q        <= dl_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      done_q      <= done_d;
      status_q    <= status_d;
      len_q       <= len_d;
    end
  end

  assign o_rx_valid  = valid_q;
  assign o_rx_data   = data_q;
  assign o_rx_sof    = sof_q;
  assign o_rx_eof    = eof_q;
  assign o_rx_done   = done_q;
  assign o_rx_status = status_q;
  assign o_rx_len    = len_q;

endmodule
`default_nettype wire

// File: tb/tb_mii_rx_mac.sv
`default_nettype none
// ============================================================================
// tb_mii_rx_mac : directed frames into mii_rx_mac with hand-derived expectations
// ============================================================================
module tb_mii_rx_mac;

  localparam logic [47:0] C_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] C_BC  = 48'hFF_FF_FF_FF_FF_FF;

  logic        clk;
  logic        rstn;
  logic        dv;
  logic        er;
  logic [3:0]  nib;
  logic        o_rx_valid;
  logic [7:0]  o_rx_data;
  logic        o_rx_sof;
  logic        o_rx_eof;
  logic        o_rx_done;
  logic [4:0]  o_rx_status;
  logic [10:0] o_rx_len;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  frm[$];
  logic [7:0]  got_data[$];
  logic        got_sof[$];
  logic        got_eof[$];
  logic [4:0]  got_stat[$];
  logic [10:0] got_len[$];

  mii_rx_mac dut (
    .i_rx_clk      (clk),
    .i_rstn        (rstn),
    .i_mii_rx_dv   (dv),
    .i_mii_rx_er   (er),
    .i_mii_rx_data (nib),
    .o_rx_valid    (o_rx_valid),
    .o_rx_data     (o_rx_data),
    .o_rx_sof      (o_rx_sof),
    .o_rx_eof      (o_rx_eof),
    .o_rx_done     (o_rx_done),
    .o_rx_status   (o_rx_status),
    .o_rx_len      (o_rx_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      if (o_rx_valid) begin
        got_data.push_back(o_rx_data);
        got_sof.push_back(o_rx_sof);
        got_eof.push_back(o_rx_eof);
      end
      if (o_rx_done) begin
        got_stat.push_back(o_rx_status);
        got_len.push_back(o_rx_len);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // DA, fixed SA, EtherType 0x0800, patterned payload, then the FCS LSB first.
  task automatic build_frame(input logic [47:0] da, input int total);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'(8'h10 + i));
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    for (int i = 14; i < total - 4; i++) frm.push_back(8'((i * 7 + 3) & 8'hFF));
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_byte(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic drive(input logic d_dv, input logic d_er, input logic [3:0] d_nib);
    @(posedge clk);
    #1;
    dv  = d_dv;
    er  = d_er;
    nib = d_nib;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 4'h0);
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_sof.delete();
    got_eof.delete();
    got_stat.delete();
    got_len.delete();
  endtask

  // er_nib: nibble index (from DA) carrying er=1, -1 for none.
  // rst_byte: byte index at which reset is held for two bytes, -1 for none.
  task automatic send_frame(input bit extra_nib, input int er_nib, input int rst_byte);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 4'h5);
      drive(1'b1, 1'b0, 4'h5);
    end
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    foreach (frm[i]) begin
      drive(1'b1, (er_nib == 2*i), frm[i][3:0]);
      if (i == rst_byte) begin
        rstn = 1'b0;
        #2;
        check("rst_outputs_zero",
              {4'd0, o_rx_valid, o_rx_data, o_rx_sof, o_rx_eof, o_rx_done, o_rx_status, o_rx_len},
              32'd0);
      end
      drive(1'b1, (er_nib == 2*i+1), frm[i][7:4]);
      if (i == rst_byte + 2) begin
        rstn = 1'b1;
        clear_mon();
      end
    end
    if (extra_nib) drive(1'b1, 1'b0, 4'hA);
    idle(24);
  endtask

  task automatic check_frame(input string name, input int exp_nout,
                             input logic [4:0] exp_stat, input logic [10:0] exp_len);
    int nbad;
    int nsof;
    int neof;
    nbad = 0;
    nsof = 0;
    neof = 0;
    check({name, "_nbytes"}, got_data.size(), exp_nout);
    foreach (got_data[i]) begin
      if (i >= frm.size() || got_data[i] !== frm[i]) nbad++;
      if (got_sof[i]) nsof++;
      if (got_eof[i]) neof++;
    end
    check({name, "_bad_bytes"}, nbad, 0);
    if (exp_nout > 0) begin
      check({name, "_sof_count"}, nsof, 1);
      check({name, "_sof_first"}, {31'd0, got_sof[0]}, 1);
      check({name, "_eof_count"}, neof, 1);
      check({name, "_eof_last"}, {31'd0, got_eof[got_eof.size()-1]}, 1);
    end
    check({name, "_done_count"}, got_stat.size(), 1);
    if (got_stat.size() > 0) begin
      check({name, "_status"}, {27'd0, got_stat[0]}, {27'd0, exp_stat});
      check({name, "_len"}, {21'd0, got_len[0]}, {21'd0, exp_len});
    end
  endtask

  initial begin
    rstn = 1'b0;
    dv   = 1'b0;
    er   = 1'b0;
    nib  = 4'h0;
    #23;
    check("reset_outputs",
          {4'd0, o_rx_valid, o_rx_data, o_rx_sof, o_rx_eof, o_rx_done, o_rx_status, o_rx_len},
          32'd0);
    rstn = 1'b1;
    idle(4);

    clear_mon();
    build_frame(C_MAC, 64);
    send_frame(1'b0, -1, -1);
    check_frame("good64", 60, 5'b10000, 11'd60);

    clear_mon();
    build_frame(C_MAC, 64);
    frm[20] = frm[20] ^ 8'h04;
    send_frame(1'b0, -1, -1);
    check_frame("bad_fcs", 60, 5'b10001, 11'd60);

    clear_mon();
    build_frame(C_BC, 40);
    send_frame(1'b0, -1, -1);
    check_frame("bcast40", 36, 5'b10010, 11'd36);

    clear_mon();
    build_frame(C_BC, 40);
    send_frame(1'b1, -1, -1);
    check_frame("align40", 36, 5'b10110, 11'd36);

    clear_mon();
    build_frame(C_MAC, 64);
    send_frame(1'b0, 45, -1);
    check_frame("mii_err", 60, 5'b11000, 11'd60);

    clear_mon();
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'h7);
    drive(1'b1, 1'b0, 4'h5);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, (i % 2 == 0) ? 4'h5 : 4'hD);
    idle(24);
    check("bad_pre_nbytes", got_data.size(), 0);
    check("bad_pre_done", got_stat.size(), 0);

    clear_mon();
    build_frame(C_MAC, 64);
    send_frame(1'b0, -1, -1);
    check_frame("after_bad_pre", 60, 5'b10000, 11'd60);

    clear_mon();
    build_frame(C_MAC, 64);
    send_frame(1'b0, -1, 30);
    check("rst_mid_nbytes", got_data.size(), 0);
    check("rst_mid_done", got_stat.size(), 0);

    clear_mon();
    build_frame(C_MAC, 64);
    send_frame(1'b0, -1, -1);
    check_frame("after_rst", 60, 5'b10000, 11'd60);

    clear_mon();
    build_frame(C_MAC, 64);
    send_frame(1'b0, -1, -1);
    check_frame("b2b_64", 60, 5'b10000, 11'd60);
    clear_mon();
    build_frame(C_MAC, 1518);
    send_frame(1'b0, -1, -1);
    check_frame("b2b_1518", 1514, 5'b10000, 11'd1514);

    clear_mon();
    build_frame(C_MAC, 1519);
    send_frame(1'b0, -1, -1);
    check_frame("long1519", 1515, 5'b10010, 11'd1515);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mii_rx_mac.md
# mii_rx_mac

MII receive front end of the MAC. It consumes the 4-bit MII RX nibble stream produced by the PHY (or the PHY model in simulation) on `i_rx_clk`. The block strips the preamble and SFD, assembles bytes, checks the CRC-32 FCS, removes the FCS, and delivers a byte stream with first/last markers to the downstream Ethernet parser. A one-cycle status strobe reports length, CRC, alignment, MII-error and address-match results for every frame that passed SFD.

## Interface

**Parameters**
- `MAC_ADDR`, 48'h02_00_00_00_00_01: station address used for the DA match.
- `PROMISC`, 0: when 1, every DA is treated as a match.
- `MIN_LEN`, 64: minimum frame length in bytes, DA through FCS inclusive.
- `MAX_LEN`, 1518: maximum frame length in bytes, DA through FCS inclusive.

**Ports**
- `i_rx_clk`, in, 1: MII receive clock. All logic is in this domain.
- `i_rstn`, in, 1: asynchronous, active-low reset.
- `i_mii_rx_dv`, in, 1: MII data valid.
- `i_mii_rx_er`, in, 1: MII receive error.
- `i_mii_rx_data`, in, 4: MII nibble, low nibble of each byte first.
- `o_rx_valid`, out, 1: byte strobe, one cycle per byte.
- `o_rx_data`, out, 8: frame byte. FCS bytes are never presented.
- `o_rx_sof`, out, 1: qualifies the first byte (DA[47:40]).
- `o_rx_eof`, out, 1: qualifies the last non-FCS byte.
- `o_rx_done`, out, 1: one-cycle end-of-frame status strobe.
- `o_rx_status`, out, 5: bit 0 crc_err, bit 1 len_err, bit 2 align_err, bit 3 mii_err, bit 4 addr_hit. Valid only with `o_rx_done`.
- `o_rx_len`, out, 11: byte count excluding FCS. Valid with `o_rx_done`.

## Operation

**Input stage**
- `dv`, `er` and `data` are registered once. All logic below uses the registered copies.

**State machine:** IDLE, PREAMBLE, DATA, DROP.
- **IDLE:** on `dv`=1 with nibble 0x5, go to PREAMBLE. On `dv`=1 with any other nibble, go to DROP.
- **PREAMBLE:**
  - Nibble 0x5: stay.
  - Nibble 0xD: go to DATA and clear the byte counter, nibble phase, CRC register (to 32'hFFFFFFFF) and mii_err flag.
  - Any other nibble: go to DROP.
  - `dv`=0: go to IDLE.
  - No status is emitted from this state.
- **DATA:**
  - Even nibble is stored as the low nibble. Odd nibble completes the byte {hi, lo}.
  - On each completed byte:
    - CRC-32 is updated (reflected polynomial 0xEDB88320, LSB first).
    - The byte counter increments, saturating at 2047.
    - The byte is pushed into a 5-entry delay line.
  - Once the delay line holds 5 bytes, every push pops its oldest entry to the output with `o_rx_valid`=1. `o_rx_sof`=1 on the first pop of the frame.
  - `er`=1 on any DATA cycle sets mii_err.
  - Bytes 0..5 are compared with `MAC_ADDR` (MSB byte first) and with FF:FF:FF:FF:FF:FF. addr_hit = exact match, or broadcast, or `PROMISC`.
  - `dv`=0 ends the frame:
    - The oldest delay-line entry, if the counter is ≥5, is popped with `o_rx_valid`=1 and `o_rx_eof`=1. `o_rx_sof` is also 1 if it is the first byte. The remaining 4 entries (the FCS) are discarded.
    - Next cycle: `o_rx_done`=1 with the status fields below. Then go to IDLE.
- **Status fields:**
  - crc_err = final CRC register ≠ 32'hDEBB20E3.
  - len_err = count < `MIN_LEN` or count > `MAX_LEN`.
  - align_err = the frame ended on an odd nibble. The dangling nibble is discarded and not CRC'd.
  - `o_rx_len` = count − 4, or 0 if count < 4.
- **DROP:** no output. Go to IDLE when `dv`=0.
- **Frames shorter than 5 bytes** (count ≤ 4): no byte and no eof is emitted. `o_rx_done` still fires, with len_err=1.

**Reset**
- All outputs are 0. State is IDLE and the delay line is empty.
- If registered `dv` is 1 on the first cycle after reset release, the block goes to DROP, so it never locks onto a mid-frame stream.

## Timing

- Input register adds 1 cycle.
- A byte completes on the cycle its high nibble is processed. The popped byte is registered, so `o_rx_valid` rises 1 cycle after the completing high nibble is processed.
- Bytes are spaced 2 cycles apart. `o_rx_valid` never asserts on consecutive cycles, except that the eof pop may follow a normal pop by 1 cycle.
- eof pop occurs 1 cycle after registered `dv` falls. `o_rx_done` occurs 1 cycle after the eof pop.
- The first byte of a back-to-back frame can arrive no earlier than 2 cycles after `o_rx_done`, which meets the minimum IFG.
- There is no back-pressure. The consumer must accept every `o_rx_valid` byte.

## Test plan

- **Good frame:** 7×0x55, 0xD5, 60-byte payload with DA = `MAC_ADDR`, then a correct FCS (64 bytes total). Expect 60 bytes out in order, sof on byte 0, eof on byte 59, then `o_rx_done` with status 5'b10000 and `o_rx_len`=60.
- **Corrupted FCS:** same frame with one payload bit flipped. Expect identical byte stream, status crc_err=1, addr_hit=1.
- **Errors:**
  - Broadcast DA, 40-byte frame with valid FCS: status 5'b10010 (len_err, addr_hit), `o_rx_len`=36.
  - Same frame with one extra nibble before `dv` drops: align_err=1.
  - `i_mii_rx_er` pulsed mid-frame: mii_err=1.
- **Bad preamble:** 0x55, 0x57, … then `dv` high for 20 nibbles. Expect no `o_rx_valid` and no `o_rx_done`. A correct frame sent next is received normally.
- **Reset mid-frame:** assert `i_rstn`=0 at byte 30 while `dv` stays high. Expect all outputs 0 and no eof or done for that frame. After release, stay in DROP until `dv`=0. The following good frame is received with correct status.
- **Back-to-back:** two good frames (64 and 1518 bytes) with a 12-byte IFG. Expect two done strobes, lengths 60 and 1514, status 5'b10000 each. Also send a 1519-byte frame: expect len_err=1.
